// File: rtl/stream_sink_bp_if.sv
// Stream handshake bundle for stream_sink_bp: upstream beat inputs plus the
// registered backpressure and captured-beat outputs.
interface stream_sink_bp_if #(
  parameter int unsigned DATA_W = 8
) ();
  logic              valid_in;
  logic [DATA_W-1:0] data_in;
  logic              last_in;
  logic              ready_out;
  logic              valid_out;
  logic [DATA_W-1:0] data;
  logic              last;

  modport master (
    output valid_in, data_in, last_in,
    input  ready_out, valid_out, data, last
  );

  modport slave (
    input  valid_in, data_in, last_in,
    output ready_out, valid_out, data, last
  );
endinterface

// File: rtl/stream_sink_bp.sv
// Stream sink with selectable backpressure (always/periodic/LFSR-random/never)
// and beat/packet counters. Define SINK_PROTO_CHECK_EN for the upstream protocol checker.
module stream_sink_bp #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned STALL_W   = 3,
  parameter int unsigned ON_CYC    = 2,
  parameter int unsigned OFF_CYC   = 1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  stream_sink_bp_if.slave  s,
  output logic [CNT_W-1:0] beat_cnt,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic             proto_err
);
  localparam int unsigned LFSR_W = 16;
  localparam int unsigned PERIOD = ON_CYC + OFF_CYC;
  localparam int unsigned PH_W   = $clog2(PERIOD + 1);

  localparam logic [1:0] MODE_ALWAYS   = 2'd0;
  localparam logic [1:0] MODE_PERIODIC = 2'd1;
  localparam logic [1:0] MODE_RANDOM   = 2'd2;
  localparam logic [1:0] MODE_NEVER    = 2'd3;

  typedef enum logic {ST_READY, ST_STALL} state_t;

  state_t              state_q, state_d;
  logic [STALL_W-1:0]  stall_q, stall_d;
  logic [PH_W-1:0]     phase_q, phase_d, phase_cur;
  logic [1:0]          mode_q;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic                ready_d;
  logic                accept;
  logic                mode_chg;
  logic                fb;

  assign accept   = s.valid_in && s.ready_out;
  assign mode_chg = (mode != mode_q);
  // Fibonacci LFSR, taps 16,14,13,11
  assign fb       = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
  assign lfsr_d   = {fb, lfsr_q[LFSR_W-1:1]};

  // ready_out is registered, so ready_d is the readiness of the coming cycle
  always_comb begin
    state_d   = state_q;
    stall_d   = stall_q;
    phase_d   = '0;
    ready_d   = 1'b0;
    phase_cur = mode_chg ? '0 : phase_q;
    case (mode)
      MODE_ALWAYS: begin
        state_d = ST_READY;
        stall_d = '0;
        ready_d = 1'b1;
      end
      MODE_PERIODIC: begin
        state_d = ST_READY;
        stall_d = '0;
        ready_d = (phase_cur < PH_W'(ON_CYC));
        phase_d = (phase_cur == PH_W'(PERIOD - 1)) ? '0 : phase_cur + PH_W'(1);
      end
      MODE_RANDOM: begin
        if (mode_chg) begin
          state_d = ST_READY;
          stall_d = '0;
        end else begin
          case (state_q)
            ST_READY: begin
              if (accept && (lfsr_q[STALL_W-1:0] != '0)) begin
                state_d = ST_STALL;
                stall_d = lfsr_q[STALL_W-1:0];
              end
            end
            ST_STALL: begin
              if (stall_q <= STALL_W'(1)) begin
                state_d = ST_READY;
                stall_d = '0;
              end else begin
                stall_d = stall_q - STALL_W'(1);
              end
            end
            default: state_d = ST_READY;
          endcase
        end
        ready_d = (state_d == ST_READY);
      end
      MODE_NEVER: begin
        state_d = ST_READY;
        stall_d = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_READY;
      stall_q     <= '0;
      phase_q     <= '0;
      mode_q      <= MODE_ALWAYS;
      lfsr_q      <= LFSR_SEED;
      s.ready_out <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_q     <= stall_d;
      phase_q     <= phase_d;
      mode_q      <= mode;
      lfsr_q      <= lfsr_d;
      s.ready_out <= ready_d;
    end
  end

  // Capture of accepted beats and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s.valid_out <= 1'b0;
      s.data      <= '0;
      s.last      <= 1'b0;
      beat_cnt    <= '0;
      pkt_cnt     <= '0;
    end else begin
      s.valid_out <= accept;
      if (accept) begin
        s.data   <= DATA_W'(s.data_in);
        s.last   <= s.last_in;
        beat_cnt <= beat_cnt + CNT_W'(1);
        if (s.last_in) pkt_cnt <= pkt_cnt + CNT_W'(1);
      end
    end
  end

`ifdef SINK_PROTO_CHECK_EN
  logic              pend_q;
  logic [DATA_W-1:0] hold_data_q;
  logic              hold_last_q;

  // A stalled beat must stay valid and unchanged until it is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q      <= 1'b0;
      hold_data_q <= '0;
      hold_last_q <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      pend_q      <= s.valid_in && !s.ready_out;
      hold_data_q <= s.data_in;
      hold_last_q <= s.last_in;
      if (pend_q && (!s.valid_in || (s.data_in != hold_data_q) || (s.last_in != hold_last_q)))
        proto_err <= 1'b1;
    end
  end
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_stream_sink_bp.sv
// Self-checking bench for stream_sink_bp: directed scenarios plus random traffic,
// compared against a cycle-level behavioural model of the sink's rules.
module tb_stream_sink_bp;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned STALL_W = 3;
  localparam int unsigned ON_CYC  = 2;
  localparam int unsigned OFF_CYC = 1;
  localparam logic [15:0] SEED    = 16'hACE1;
`ifdef SINK_PROTO_CHECK_EN
  localparam bit PROTO_EN = 1'b1;
`else
  localparam bit PROTO_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       mode;
  logic [CNT_W-1:0] beat_cnt, pkt_cnt;
  logic             proto_err;

  stream_sink_bp_if #(.DATA_W(DATA_W)) bus ();

  stream_sink_bp #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .STALL_W(STALL_W),
    .ON_CYC(ON_CYC), .OFF_CYC(OFF_CYC), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .s(bus),
    .beat_cnt(beat_cnt), .pkt_cnt(pkt_cnt), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic              e_ready, e_valid, e_last, e_proto, m_acc, m_pend, m_plast;
  logic [DATA_W-1:0] e_data, m_pdata;
  int                e_beat, e_pkt, m_cyc, m_stall;
  logic [15:0]       m_lfsr;
  logic [1:0]        m_prev;
  int                exp_stalls[$];
  int                obs_stalls[$];

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    int   taps[4] = '{16, 14, 13, 11};
    logic f = 1'b0;
    foreach (taps[i]) f ^= v[16 - taps[i]];
    return {f, v[15:1]};
  endfunction

  task automatic model_reset();
    e_ready = 1'b0; e_valid = 1'b0; e_last = 1'b0; e_data = '0; e_proto = 1'b0;
    e_beat = 0; e_pkt = 0; m_acc = 1'b0; m_pend = 1'b0; m_pdata = '0; m_plast = 1'b0;
    m_cyc = 0; m_stall = 0; m_lfsr = SEED; m_prev = 2'd0;
  endtask

  task automatic model_step();
    logic chg;
    m_acc = bus.valid_in && e_ready;
    if (PROTO_EN && m_pend &&
        (!bus.valid_in || bus.data_in !== m_pdata || bus.last_in !== m_plast))
      e_proto = 1'b1;
    m_pend  = bus.valid_in && !e_ready;
    m_pdata = bus.data_in;
    m_plast = bus.last_in;
    e_valid = m_acc;
    if (m_acc) begin
      e_data = bus.data_in;
      e_last = bus.last_in;
      e_beat++;
      if (bus.last_in) e_pkt++;
    end
    chg    = (mode != m_prev);
    m_prev = mode;
    if (chg) begin m_cyc = 0; m_stall = 0; end
    case (mode)
      2'd0: e_ready = 1'b1;
      2'd3: e_ready = 1'b0;
      2'd1: begin
        e_ready = ((m_cyc % (ON_CYC + OFF_CYC)) < ON_CYC);
        m_cyc++;
      end
      default: begin
        if (chg) e_ready = 1'b1;
        else if (m_stall > 0) begin m_stall--; e_ready = 1'b0; end
        else if (m_acc && m_lfsr[STALL_W-1:0] != '0) begin
          exp_stalls.push_back(int'(m_lfsr[STALL_W-1:0]));
          m_stall = int'(m_lfsr[STALL_W-1:0]) - 1;
          e_ready = 1'b0;
        end else e_ready = 1'b1;
      end
    endcase
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("ready_out", 64'(bus.ready_out), 64'(e_ready));
    chk("valid_out", 64'(bus.valid_out), 64'(e_valid));
    chk("data",      64'(bus.data),      64'(e_data));
    chk("last",      64'(bus.last),      64'(e_last));
    chk("beat_cnt",  64'(beat_cnt),      64'(CNT_W'(e_beat)));
    chk("pkt_cnt",   64'(pkt_cnt),       64'(CNT_W'(e_pkt)));
    chk("proto_err", 64'(proto_err),     64'(e_proto));
  endtask

  // Source: 0 idle-hold, 1 sequential beats, 2 random compliant traffic
  int src, seq_k, seq_n, run0;
  bit seq_pkt4, meas;

  task automatic drive_seq();
    if (seq_k < seq_n) begin
      bus.valid_in = 1'b1;
      bus.data_in  = DATA_W'(seq_k + 1);
      bus.last_in  = seq_pkt4 && (seq_k % 4 == 3);
    end else begin
      bus.valid_in = 1'b0;
      bus.last_in  = 1'b0;
    end
  endtask

  task automatic start_seq(input int n, input bit pkt4);
    seq_k = 0; seq_n = n; seq_pkt4 = pkt4; src = 1;
    drive_seq();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_all();
      if (meas) begin
        if (!bus.ready_out) run0++;
        else if (run0 > 0) begin obs_stalls.push_back(run0); run0 = 0; end
      end
      case (src)
        1: begin if (m_acc) seq_k++; drive_seq(); end
        2: if (!(bus.valid_in && !m_acc)) begin
             bus.valid_in = ($urandom_range(0, 3) != 0);
             bus.data_in  = DATA_W'($urandom);
             bus.last_in  = ($urandom_range(0, 3) == 0);
           end
        default: ;
      endcase
    end
  endtask

  task automatic do_reset(input logic [1:0] m);
    rst = 1'b1; mode = m; src = 0;
    bus.valid_in = 1'b0; bus.data_in = '0; bus.last_in = 1'b0;
    run(2);
  endtask

  initial begin
    logic [DATA_W-1:0] got[$];
    logic              pat[9];
    int                cur, maxrun, b0, nv, n;

    rst = 1'b1; mode = 2'd0; src = 0; meas = 1'b0; run0 = 0;
    bus.valid_in = 1'b0; bus.data_in = '0; bus.last_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(bus.ready_out), 64'd0);
    chk("rst_valid", 64'(bus.valid_out), 64'd0);
    chk("rst_beat",  64'(beat_cnt), 64'd0);

    // Mode 0: ten beats accepted back to back
    start_seq(10, 1'b0);
    rst = 1'b0;
    cur = 0; maxrun = 0;
    for (int i = 0; i < 13; i++) begin
      run(1);
      if (bus.valid_out) begin got.push_back(bus.data); cur++; end else cur = 0;
      if (cur > maxrun) maxrun = cur;
    end
    chk("m0_consecutive", 64'(maxrun), 64'd10);
    chk("m0_nbeats", 64'(got.size()), 64'd10);
    for (int i = 0; i < got.size() && i < 10; i++)
      chk($sformatf("m0_data%0d", i), 64'(got[i]), 64'(i + 1));
    chk("m0_beat_cnt", 64'(beat_cnt), 64'd10);

    // Mode 1: ready pattern 1,1,0 and 6 accepts in 9 cycles
    mode = 2'd1;
    start_seq(40, 1'b0);
    run(1);
    b0 = e_beat;
    for (int i = 0; i < 9; i++) begin
      pat[i] = bus.ready_out;
      run(1);
    end
    for (int i = 0; i < 9; i++)
      chk($sformatf("m1_ready%0d", i), 64'(pat[i]), 64'((i % 3) < 2));
    chk("m1_beats9", 64'(beat_cnt), 64'(CNT_W'(b0 + 6)));

    // Mode 2 from seed: stall lengths and packet count
    do_reset(2'd2);
    exp_stalls.delete(); obs_stalls.delete(); run0 = 0;
    start_seq(8, 1'b1);
    meas = 1'b1;
    rst  = 1'b0;
    for (int i = 0; i < 200 && e_beat < 4; i++) run(1);
    chk("m2_reach4", 64'(e_beat >= 4), 64'd1);
    chk("m2_pkt_after4", 64'(pkt_cnt), 64'd1);
    for (int i = 0; i < 200 && e_beat < 8; i++) run(1);
    run(10);
    meas = 1'b0;
    chk("m2_pkt_after8", 64'(pkt_cnt), 64'd2);
    n = (obs_stalls.size() < exp_stalls.size()) ? obs_stalls.size() : exp_stalls.size();
    chk("m2_stalls_seen", 64'(n >= 1), 64'd1);
    for (int i = 0; i < n; i++)
      chk($sformatf("m2_stall%0d", i), 64'(obs_stalls[i]), 64'(exp_stalls[i]));

    // Mode 3: nothing accepted; mode 0 afterwards accepts promptly
    do_reset(2'd3);
    rst = 1'b0;
    start_seq(5, 1'b0);
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      run(1);
      if (bus.valid_out) nv++;
    end
    chk("m3_no_valid", 64'(nv), 64'd0);
    chk("m3_beat_cnt", 64'(beat_cnt), 64'd0);
    mode = 2'd0;
    run(2);
    chk("m3to0_valid", 64'(bus.valid_out), 64'd1);
    chk("m3to0_data",  64'(bus.data), 64'd1);
    chk("m3to0_beat",  64'(beat_cnt), 64'd1);

    // Reset in the first cycle of a 5-cycle stall
    mode = 2'd2; src = 0; bus.valid_in = 1'b0; bus.last_in = 1'b0;
    run(2);
    for (int i = 0; i < 2000 && !(e_ready && m_lfsr[STALL_W-1:0] == 3'd5); i++) run(1);
    chk("stall5_found", 64'(e_ready && m_lfsr[STALL_W-1:0] == 3'd5), 64'd1);
    bus.valid_in = 1'b1; bus.data_in = 8'h55; bus.last_in = 1'b0;
    run(1);
    bus.valid_in = 1'b0;
    chk("stall5_ready", 64'(bus.ready_out), 64'd0);
    rst = 1'b1;
    #1;
    chk("stall5_rst_ready", 64'(bus.ready_out), 64'd0);
    chk("stall5_rst_beat",  64'(beat_cnt), 64'd0);
    chk("stall5_rst_pkt",   64'(pkt_cnt), 64'd0);
    chk("stall5_rst_valid", 64'(bus.valid_out), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run(1);
    chk("stall5_post_ready", 64'(bus.ready_out), 64'd1);
    run(3);
    chk("stall5_still_ready", 64'(bus.ready_out), 64'd1);

    // Random modes and compliant random traffic
    do_reset(2'd0);
    rst = 1'b0;
    src = 2;
    for (int r = 0; r < 16; r++) begin
      mode = 2'($urandom_range(0, 3));
      run($urandom_range(5, 40));
    end

    // Valid dropped while stalled
    do_reset(2'd3);
    rst = 1'b0;
    run(2);
    bus.valid_in = 1'b1; bus.data_in = 8'h33;
    run(1);
    bus.valid_in = 1'b0;
    run(1);
    chk("proto_set", 64'(proto_err), 64'(PROTO_EN));
    run(5);
    chk("proto_held", 64'(proto_err), 64'(PROTO_EN));
    do_reset(2'd3);
    chk("proto_cleared", 64'(proto_err), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stream_sink_bp.md
STREAM_SINK_BP -- requirements
Module: stream_sink_bp

Interface
REQ-001 SHALL have parameter DATA_W, default 8, stream data width in bits.
REQ-002 SHALL have parameter CNT_W, default 16, width of the beat and packet counters.
REQ-003 SHALL have parameter STALL_W, default 3, stall-length field width; max random stall is 2^STALL_W-1 cycles.
REQ-004 SHALL have parameter ON_CYC, default 2, ready-high cycles per period in mode 1 (>=1).
REQ-005 SHALL have parameter OFF_CYC, default 1, ready-low cycles per period in mode 1 (>=1).
REQ-006 SHALL have parameter LFSR_SEED, default 16'hACE1, nonzero LFSR reset value.
REQ-007 SHALL have port clk, input, 1, sole clock; all logic on the rising edge.
REQ-008 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-009 SHALL have port mode, input, 2: 0 always-ready, 1 periodic, 2 random-stall, 3 never-ready.
REQ-010 SHALL have port valid_in, input, 1, upstream beat valid.
REQ-011 SHALL have port data_in, input, DATA_W, upstream beat data.
REQ-012 SHALL have port last_in, input, 1, marks the final beat of a packet.
REQ-013 SHALL have port ready_out, output, 1, registered backpressure to upstream.
REQ-014 SHALL have port valid_out, output, 1, one-cycle pulse per accepted beat.
REQ-015 SHALL have port data, output, DATA_W, captured data of the last accepted beat.
REQ-016 SHALL have port last, output, 1, captured last_in, qualified by valid_out.
REQ-017 SHALL have ports beat_cnt and pkt_cnt, output, CNT_W, accepted-beat and accepted-packet counts.
REQ-018 SHALL have port proto_err, output, 1, sticky upstream protocol-violation flag.

Function
REQ-019 SHALL define accept = valid_in && ready_out, evaluated each rising edge.
REQ-020 SHALL on accept, in the next cycle, drive valid_out=1, data=data_in, last=last_in; otherwise valid_out=0 and data/last hold.
REQ-021 SHALL increment beat_cnt on every accept and pkt_cnt on accept with last_in=1; both wrap modulo 2^CNT_W.
REQ-022 SHALL run a 16-bit Fibonacci LFSR (taps 16,14,13,11) from LFSR_SEED, advancing every cycle in every mode.
REQ-023 SHALL in mode 0 drive ready_out=1 every cycle after reset.
REQ-024 SHALL in mode 3 drive ready_out=0 every cycle.
REQ-025 SHALL in mode 1 repeat ON_CYC cycles ready_out=1 then OFF_CYC cycles ready_out=0, independent of traffic.
REQ-026 SHALL in mode 2 use a two-state FSM: READY (ready_out=1) -> STALL on accept, loading stall_cnt=LFSR[STALL_W-1:0]; if loaded value is 0, it SHALL remain READY.
REQ-027 SHALL in STALL drive ready_out=0, decrement stall_cnt each cycle, and return to READY the cycle after stall_cnt reaches 1.
REQ-028 SHALL, on any change of mode, clear stall_cnt, restart the mode-1 phase at the first ON cycle, and enter READY; the new mode applies from the next cycle.
REQ-029 SHALL never accept a beat while ready_out=0, even if valid_in is high.

Reset
REQ-030 SHALL while rst=1 immediately force ready_out=0, valid_out=0, data=0, last=0, beat_cnt=0, pkt_cnt=0, proto_err=0, stall_cnt=0, FSM=READY, phase=0, LFSR=LFSR_SEED.
REQ-031 SHALL after rst deasserts drive ready_out per mode from the first clock edge; a reset mid-stall or mid-packet discards all in-flight state.

Configuration
REQ-032 SHALL with SINK_PROTO_CHECK_EN defined set proto_err when, after a cycle with valid_in=1 and ready_out=0, the next cycle has valid_in=0 or changed data_in/last_in; cleared only by rst.
REQ-033 SHALL without SINK_PROTO_CHECK_EN tie proto_err to 0 and omit the checker registers.

Verification
REQ-034 SHALL test mode 0, valid_in held high, data 1..10 -> valid_out pulses 10 consecutive cycles, data 1..10, beat_cnt=10.
REQ-035 SHALL test mode 1, ON_CYC=2, OFF_CYC=1, continuous valid -> ready_out pattern 1,1,0 repeating; 6 beats accepted in 9 cycles.
REQ-036 SHALL test mode 2, seed 16'hACE1, 4-beat packets with last on beat 4 -> stall lengths match a reference LFSR model; pkt_cnt=1 after beat 4.
REQ-037 SHALL test mode 3 for 20 cycles with valid_in=1 -> no valid_out, beat_cnt=0; switch to mode 0 -> acceptance the next cycle.
REQ-038 SHALL test rst pulse during STALL with stall_cnt=5 -> ready_out=0 immediately, counters 0, FSM READY after release.
REQ-039 SHALL with SINK_PROTO_CHECK_EN test valid_in dropped while ready_out=0 -> proto_err=1 and held until rst.
